// File: rtl/phy_reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// phy_reg_wb_arbiter
//   Shares the physical register file write ports among the functional units.
//   Each FU hands over one (tag, value) result per cycle into its own 1-entry
//   holding slot. Every cycle up to NUM_WR_PORTS occupied slots are granted in
//   round-robin order. Granted results are registered onto the write ports.
//
//   Handshake: an offer transfers on a rising edge where fu_wb_valid[i] and
//   fu_wb_ready[i] are both high. ready is combinational from slot state and
//   grant only (never from valid). A producer that sees valid without ready
//   keeps tag/value stable until the transfer.
//
// Ports
//   clk, reset         clock, synchronous active-high reset (dominates flush)
//   flush              discard all held results; no offer accepted that cycle
//   fu_wb_valid/tag/val  per-FU result offer
//   fu_wb_ready        per-FU acceptance
//   dst_wr_en          per-port write enable, pulses for one cycle per grant
//   dst_phy_reg/dst_val  per-port write address/data, hold when not enabled
//   slots_busy         registered count of occupied holding slots
// ---------------------------------------------------------------------------
module phy_reg_wb_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int NUM_WR_PORTS = 2,
   parameter int TAG_W        = 6,
   parameter int VAL_W        = 32,
   localparam int PTR_W       = $clog2(NUM_REQ),
   localparam int CNT_W       = $clog2(NUM_REQ + 1)
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 flush,
   input  logic [NUM_REQ-1:0]                   fu_wb_valid,
   input  logic [NUM_REQ-1:0][TAG_W-1:0]        fu_wb_tag,
   input  logic [NUM_REQ-1:0][VAL_W-1:0]        fu_wb_val,
   output logic [NUM_REQ-1:0]                   fu_wb_ready,
   output logic [NUM_WR_PORTS-1:0]              dst_wr_en,
   output logic [NUM_WR_PORTS-1:0][TAG_W-1:0]   dst_phy_reg,
   output logic [NUM_WR_PORTS-1:0][VAL_W-1:0]   dst_val,
   output logic [CNT_W-1:0]                     slots_busy
);

   logic [NUM_REQ-1:0]                 slot_v_q, slot_v_d;
   logic [NUM_REQ-1:0][TAG_W-1:0]      slot_tag_q, slot_tag_d;
   logic [NUM_REQ-1:0][VAL_W-1:0]      slot_val_q, slot_val_d;
   logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
   logic [NUM_WR_PORTS-1:0]            dst_wr_en_q, dst_wr_en_d;
   logic [NUM_WR_PORTS-1:0][TAG_W-1:0] dst_phy_reg_q, dst_phy_reg_d;
   logic [NUM_WR_PORTS-1:0][VAL_W-1:0] dst_val_q, dst_val_d;
   logic [CNT_W-1:0]                   slots_busy_q, slots_busy_d;

   logic [NUM_REQ-1:0]                 grant;
   logic [NUM_REQ-1:0]                 accept;
   logic [NUM_WR_PORTS-1:0]            port_en;
   logic [NUM_WR_PORTS-1:0][PTR_W-1:0] port_sel;
   logic [PTR_W-1:0]                   last_idx;
   logic [PTR_W:0]                     scan_sum;
   logic [PTR_W-1:0]                   scan_idx;
   int                                 occ_cnt;

   // Round-robin scan starting at rr_ptr; the k-th occupied slot found goes
   // to write port k until the ports run out.
   always_comb begin
      grant    = '0;
      port_en  = '0;
      port_sel = '0;
      last_idx = rr_ptr_q;
      occ_cnt  = 0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (scan_sum >= (PTR_W+1)'(NUM_REQ))
            scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
         scan_idx = scan_sum[PTR_W-1:0];
         if (slot_v_q[scan_idx] && (occ_cnt < NUM_WR_PORTS)) begin
            grant[scan_idx] = 1'b1;
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
               if (occ_cnt == p) begin
                  port_en[p]  = 1'b1;
                  port_sel[p] = scan_idx;
               end
            end
            last_idx = scan_idx;
            occ_cnt  = occ_cnt + 1;
         end
      end
   end

   // A slot being drained this cycle can take a new offer at the same edge.
   assign fu_wb_ready = (reset || flush) ? '0 : (~slot_v_q | grant);
   assign accept      = fu_wb_valid & fu_wb_ready;

   always_comb begin
      slot_v_d      = slot_v_q;
      slot_tag_d    = slot_tag_q;
      slot_val_d    = slot_val_q;
      rr_ptr_d      = rr_ptr_q;
      dst_wr_en_d   = '0;
      dst_phy_reg_d = dst_phy_reg_q;
      dst_val_d     = dst_val_q;
      slots_busy_d  = '0;

      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i])
            slot_v_d[i] = 1'b0;
         // Tag 0 is the hardwired zero register: accept and drop.
         if (accept[i] && (fu_wb_tag[i] != '0)) begin
            slot_v_d[i]   = 1'b1;
            slot_tag_d[i] = fu_wb_tag[i];
            slot_val_d[i] = fu_wb_val[i];
         end
      end

      if (flush) begin
         // Grants seen during a flush are discarded, the pointer stays put.
         slot_v_d = '0;
      end else begin
         dst_wr_en_d = port_en;
         if (|grant) begin
            if (last_idx == PTR_W'(NUM_REQ - 1))
               rr_ptr_d = '0;
            else
               rr_ptr_d = last_idx + 1'b1;
         end
      end

      for (int p = 0; p < NUM_WR_PORTS; p++) begin
         if (dst_wr_en_d[p]) begin
            dst_phy_reg_d[p] = slot_tag_q[port_sel[p]];
            dst_val_d[p]     = slot_val_q[port_sel[p]];
         end
      end

      for (int i = 0; i < NUM_REQ; i++)
         slots_busy_d = slots_busy_d + CNT_W'(slot_v_d[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_v_q      <= '0;
         slot_tag_q    <= '0;
         slot_val_q    <= '0;
         rr_ptr_q      <= '0;
         dst_wr_en_q   <= '0;
         dst_phy_reg_q <= '0;
         dst_val_q     <= '0;
         slots_busy_q  <= '0;
      end else begin
         slot_v_q      <= slot_v_d;
         slot_tag_q    <= slot_tag_d;
         slot_val_q    <= slot_val_d;
         rr_ptr_q      <= rr_ptr_d;
         dst_wr_en_q   <= dst_wr_en_d;
         dst_phy_reg_q <= dst_phy_reg_d;
         dst_val_q     <= dst_val_d;
         slots_busy_q  <= slots_busy_d;
      end
   end

   assign dst_wr_en   = dst_wr_en_q;
   assign dst_phy_reg = dst_phy_reg_q;
   assign dst_val     = dst_val_q;
   assign slots_busy  = slots_busy_q;

endmodule

// File: tb/tb_phy_reg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_phy_reg_wb_arbiter
//   Drives the arbiter with directed scenarios followed by random traffic.
//   A reference model (per-FU held results, a round-robin start index and the
//   last values written to each port) predicts ready each cycle and the full
//   write-port picture for the following cycle; the prediction is queued and
//   a negedge monitor pops and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_phy_reg_wb_arbiter;
   localparam int N  = 4;
   localparam int P  = 2;
   localparam int TW = 6;
   localparam int VW = 32;
   localparam int CW = $clog2(N + 1);
   localparam int DW = P + P * TW + P * VW;
   localparam int W  = 32 + DW + CW;

   // ---------------- clock / reset ----------------
   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  flush = 1'b0;
   logic [N-1:0]          fu_wb_valid = '0;
   logic [N-1:0][TW-1:0]  fu_wb_tag = '0;
   logic [N-1:0][VW-1:0]  fu_wb_val = '0;
   logic [N-1:0]          fu_wb_ready;
   logic [P-1:0]          dst_wr_en;
   logic [P-1:0][TW-1:0]  dst_phy_reg;
   logic [P-1:0][VW-1:0]  dst_val;
   logic [CW-1:0]         slots_busy;

   always #5 clk = ~clk;

   phy_reg_wb_arbiter #(.NUM_REQ(N), .NUM_WR_PORTS(P), .TAG_W(TW), .VAL_W(VW)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .fu_wb_valid (fu_wb_valid),
      .fu_wb_tag   (fu_wb_tag),
      .fu_wb_val   (fu_wb_val),
      .fu_wb_ready (fu_wb_ready),
      .dst_wr_en   (dst_wr_en),
      .dst_phy_reg (dst_phy_reg),
      .dst_val     (dst_val),
      .slots_busy  (slots_busy)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;

   // reference model
   logic                  m_v[N];
   logic [TW-1:0]         m_tag[N];
   logic [VW-1:0]         m_val[N];
   int                    m_rr = 0;
   logic [P-1:0]          m_wr_en = '0;
   logic [P-1:0][TW-1:0]  m_phy = '0;
   logic [P-1:0][VW-1:0]  m_dval = '0;
   logic [CW-1:0]         m_busy = '0;

   // pending offers held by each producer until accepted
   logic                  pend_v[N];
   logic [TW-1:0]         pend_t[N];
   logic [VW-1:0]         pend_d[N];

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         if (exp_q[0][W-1 -: 32] == 32'(cyc)) begin
            e = exp_q.pop_front();
            chk("dst", 128'({dst_wr_en, dst_phy_reg, dst_val}), 128'(e[W-33 -: DW]));
            chk("busy", 128'(slots_busy), 128'(e[CW-1:0]));
         end else if (exp_q[0][W-1 -: 32] < 32'(cyc)) begin
            e = exp_q.pop_front();
            chk("stale_entry", 128'(cyc), 128'(e[W-1 -: 32]));
         end
      end
   end

   // ---------------- driver ----------------
   function automatic logic [TW-1:0] new_tag();
      int start;
      logic [TW-1:0] t;
      logic clash;
      start = $urandom_range(1, 63);
      for (int k = 0; k < 63; k++) begin
         t = TW'(((start - 1 + k) % 63) + 1);
         clash = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (m_v[i] && m_tag[i] == t) clash = 1'b1;
            if (pend_v[i] && pend_t[i] == t) clash = 1'b1;
         end
         if (!clash) return t;
      end
      return '0;
   endfunction

   task automatic offer(input int i, input logic [TW-1:0] t, input logic [VW-1:0] d);
      pend_v[i] = 1'b1;
      pend_t[i] = t;
      pend_d[i] = d;
   endtask

   // One clock cycle: drive pending offers, check ready, advance the model,
   // queue the expected write-port state for the next cycle.
   task automatic run(input logic rst, input logic fl);
      int       gl[$];
      logic     gr[N];
      logic [N-1:0] rdy_exp;
      int       idx;
      int       cnt;
      logic [31:0] c1;
      reset = rst;
      flush = fl;
      for (int i = 0; i < N; i++) begin
         fu_wb_valid[i] = pend_v[i];
         fu_wb_tag[i]   = pend_v[i] ? pend_t[i] : '0;
         fu_wb_val[i]   = pend_v[i] ? pend_d[i] : '0;
         gr[i] = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
         idx = (m_rr + k) % N;
         if (m_v[idx] && gl.size() < P) begin
            gl.push_back(idx);
            gr[idx] = 1'b1;
         end
      end
      for (int i = 0; i < N; i++)
         rdy_exp[i] = !rst && !fl && (!m_v[i] || gr[i]);
      #1;
      chk("ready", 128'(fu_wb_ready), 128'(rdy_exp));

      if (rst) begin
         for (int i = 0; i < N; i++) m_v[i] = 1'b0;
         m_rr = 0; m_wr_en = '0; m_phy = '0; m_dval = '0;
      end else if (fl) begin
         for (int i = 0; i < N; i++) m_v[i] = 1'b0;
         m_wr_en = '0;
      end else begin
         m_wr_en = '0;
         foreach (gl[j]) begin
            m_wr_en[j] = 1'b1;
            m_phy[j]   = m_tag[gl[j]];
            m_dval[j]  = m_val[gl[j]];
            m_v[gl[j]] = 1'b0;
         end
         if (gl.size() > 0) m_rr = (gl[gl.size()-1] + 1) % N;
         for (int i = 0; i < N; i++) begin
            if (pend_v[i] && rdy_exp[i] && pend_t[i] != '0) begin
               m_v[i]   = 1'b1;
               m_tag[i] = pend_t[i];
               m_val[i] = pend_d[i];
            end
         end
      end
      for (int i = 0; i < N; i++)
         if (pend_v[i] && rdy_exp[i]) pend_v[i] = 1'b0;

      cnt = 0;
      for (int i = 0; i < N; i++) cnt += int'(m_v[i]);
      m_busy = CW'(cnt);
      for (int i = 0; i < N; i++)
         for (int j = i + 1; j < N; j++)
            if (m_v[i] && m_v[j] && m_tag[i] == m_tag[j]) begin
               errors++;
               $display("FAIL dup_tag fu%0d fu%0d tag=%0d", i, j, m_tag[i]);
            end
      c1 = 32'(cyc + 1);
      exp_q.push_back({c1, m_wr_en, m_phy, m_dval, m_busy});
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < N; i++) begin
         m_v[i] = 1'b0; m_tag[i] = '0; m_val[i] = '0;
         pend_v[i] = 1'b0; pend_t[i] = '0; pend_d[i] = '0;
      end
      @(posedge clk);
      #1;

      // 1. reset held two cycles with all valids high
      for (int i = 0; i < N; i++) offer(i, TW'(40 + i), VW'(1000 + i));
      run(1'b1, 1'b0);
      chk("t1_rdy_rst", 128'(fu_wb_ready), 128'(4'b0000));
      chk("t1_wr_rst", 128'(dst_wr_en), 128'(2'b00));
      chk("t1_busy_rst", 128'(slots_busy), 128'(0));
      run(1'b1, 1'b0);
      reset = 1'b0;
      #1;
      chk("t1_rdy_rel", 128'(fu_wb_ready), 128'(4'b1111));
      run(1'b0, 1'b0);
      repeat (4) run(1'b0, 1'b0);

      // 3. contention with rr_ptr back at 0
      offer(0, 6'd5, 32'd50);
      offer(1, 6'd6, 32'd60);
      offer(2, 6'd21, 32'd210);
      offer(3, 6'd22, 32'd220);
      run(1'b0, 1'b0);
      chk("t3_rdy_mid", 128'(fu_wb_ready), 128'(4'b0011));
      run(1'b0, 1'b0);
      chk("t3_c2_tags", 128'({dst_wr_en, dst_phy_reg}), 128'({2'b11, 6'd6, 6'd5}));
      run(1'b0, 1'b0);
      chk("t3_c3_tags", 128'({dst_wr_en, dst_phy_reg}), 128'({2'b11, 6'd22, 6'd21}));

      // 2. single write, 2-cycle latency then a single pulse
      offer(1, 6'd23, 32'd144);
      run(1'b0, 1'b0);
      run(1'b0, 1'b0);
      chk("t2_wr", 128'({dst_wr_en, dst_phy_reg[0], dst_val[0]}), 128'({2'b01, 6'd23, 32'd144}));
      run(1'b0, 1'b0);
      chk("t2_pulse", 128'(dst_wr_en), 128'(2'b00));

      // 4. FU2 once to move the pointer to 3, then FU3 and FU0 streaming
      offer(2, 6'd30, 32'd7);
      run(1'b0, 1'b0);
      run(1'b0, 1'b0);
      for (int c = 0; c < 10; c++) begin
         if (!pend_v[3]) offer(3, new_tag(), $urandom);
         if (!pend_v[0]) offer(0, new_tag(), $urandom);
         run(1'b0, 1'b0);
      end
      repeat (3) run(1'b0, 1'b0);

      // 5. tag 0 is swallowed
      offer(2, 6'd0, 32'd109);
      run(1'b0, 1'b0);
      chk("t5_busy", 128'(slots_busy), 128'(0));
      run(1'b0, 1'b0);
      chk("t5_wr", 128'(dst_wr_en), 128'(2'b00));

      // 6. flush with three slots busy, then reset together with flush
      offer(0, 6'd11, 32'd1);
      offer(1, 6'd12, 32'd2);
      offer(2, 6'd13, 32'd3);
      run(1'b0, 1'b0);
      chk("t6_busy3", 128'(slots_busy), 128'(3));
      run(1'b0, 1'b1);
      chk("t6_flush", 128'({dst_wr_en, slots_busy}), 128'({2'b00, 3'd0}));
      offer(0, 6'd14, 32'd4);
      offer(1, 6'd15, 32'd5);
      run(1'b0, 1'b0);
      run(1'b0, 1'b0);
      run(1'b1, 1'b1);
      chk("t6_rst_flush", 128'({dst_wr_en, dst_phy_reg, dst_val, slots_busy}), 128'(0));

      // random traffic
      for (int c = 0; c < 600; c++) begin
         logic fl;
         logic rs;
         for (int i = 0; i < N; i++)
            if (!pend_v[i] && $urandom_range(0, 1) == 1)
               offer(i, ($urandom_range(0, 15) == 0) ? TW'(0) : new_tag(), $urandom);
         fl = ($urandom_range(0, 24) == 0);
         rs = ($urandom_range(0, 149) == 0);
         run(rs, fl);
      end

      for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
      repeat (4) run(1'b0, 1'b0);
      @(negedge clk);
      #1;
      chk("drain", 128'(exp_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
